sram_fifo_ctrl: RTL and testbench
=================================

# sram_fifo_ctrl

Synchronous FIFO controller sitting directly upstream of the dual-port synchronous SRAM. It turns a push/pop request interface into the SRAM's write-port and read-port controls (wr_en/wr_addr/data_in, rd_en/rd_addr). It maintains circular pointers, occupancy and full/empty status, and aligns the SRAM's one-cycle registered read data with a pop_valid strobe. Storage lives entirely in the SRAM instance; this block holds only pointers, count and status.

## Interface
- data_width, 8, width of one FIFO entry; matches the SRAM data width
- RAM_size, 16, FIFO depth in entries; any value from 2 to 2**address_width; need not be a power of two
- address_width, 4, SRAM address width
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- push  input  1  write request
- push_data  input  data_width  entry to write
- pop  input  1  read request
- pop_data  output  data_width  combinational pass-through of ram_rd_data; meaningful only when pop_valid=1
- pop_valid  output  1  high in the cycle after an accepted pop
- full  output  1  count == RAM_size
- empty  output  1  count == 0
- count  output  address_width+1  current occupancy, 0..RAM_size
- overflow  output  1  sticky flag: a push was rejected
- underflow  output  1  sticky flag: a pop was rejected
- ram_wr_en  output  1  drives SRAM wr_en
- ram_wr_addr  output  address_width  drives SRAM wr_addr; equals wr_ptr
- ram_wr_data  output  data_width  drives SRAM data_in; equals push_data
- ram_rd_en  output  1  drives SRAM rd_en
- ram_rd_addr  output  address_width  drives SRAM rd_addr; equals rd_ptr
- ram_rd_data  input  data_width  from SRAM data_out_port

## Operation
- pop_acc = pop & ~empty.
- push_acc = push & (~full | pop_acc). A push to a full FIFO is accepted only when a pop is accepted in the same cycle.
- Combinational outputs: ram_wr_en = push_acc and ram_rd_en = pop_acc. ram_wr_addr, ram_rd_addr and ram_wr_data come directly from the pointer and data registers/inputs.
- Pointer update: each pointer advances by 1 on its accepted operation. Wrap is explicit, RAM_size-1 -> 0, not modulo 2**address_width.
- count update: +1 on push_acc only, -1 on pop_acc only, unchanged when both or neither occur.
- full and empty are derived from the registered count, so they are glitch-free and never both high.
- Simultaneous push+pop when full: wr_ptr == rd_ptr. The SRAM read returns the old entry because its read and write happen on the same edge with nonblocking update. count stays RAM_size.
- Simultaneous push+pop when empty: only the push is accepted. underflow is set, count becomes 1, and pop_valid stays 0 in the next cycle.
- overflow is set on push & ~push_acc. underflow is set on pop & empty. Both are cleared only by rst.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, pop_valid=0, overflow=0, underflow=0.
- Reset is applied whenever rst=1, including mid-operation; entries in flight are discarded. During a rst cycle, push and pop are ignored and ram_wr_en=ram_rd_en=0. The SRAM shares rst, so its data_out reads 0 after reset.

## Timing
- Write: push_acc in cycle N writes the SRAM at edge N+1. That entry can be popped from cycle N+1 onward.
- Read latency is 1: pop_acc in cycle N gives pop_valid=1 and valid pop_data in cycle N+1.
- Back-to-back pops deliver one entry per cycle, with pop_valid continuously high.
- Status (count, full, empty) updates at the same edge as the pointers. There is no lookahead.
- Sustained throughput is 1 push plus 1 pop per cycle in every state except empty (pop blocked) and full-without-pop (push blocked).

## Test plan
- Reset, then idle: count=0, empty=1, full=0, pop_valid=0, ram_wr_en=ram_rd_en=0.
- Push 0x11..0x1F and 0x20 (16 entries), then pop 16 times: full=1 after the 16th push; pops return 0x11..0x20 in order, each with pop_valid one cycle after the pop; empty=1 at the end.
- Fill to full, then issue push 0xAA and pop in the same cycle: count stays 16, pop_data=0x11, and 0xAA is the last entry out after 15 further pops.
- Push on full without pop: the write is rejected, overflow=1 and remains set. Pop on empty: underflow=1, pop_valid=0.
- Wrap: with RAM_size=12, push and pop 30 entries at 1 per cycle: ram_wr_addr sequence wraps 11 -> 0 and data order is preserved.
- Assert rst with count=5 mid-stream: the next cycle shows count=0, empty=1, flags cleared and pointers 0. A following push of 0x5A pops back as 0x5A.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - FIFO pointer/count/status controller in front of a dual-port synchronous SRAM
module sram_fifo_ctrl #(
  parameter int data_width    = 8,
  parameter int RAM_size      = 16,
  parameter int address_width = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [data_width-1:0]    push_data,
  input  logic                     pop,
  output logic [data_width-1:0]    pop_data,
  output logic                     pop_valid,
  output logic                     full,
  output logic                     empty,
  output logic [address_width:0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     ram_wr_en,
  output logic [address_width-1:0] ram_wr_addr,
  output logic [data_width-1:0]    ram_wr_data,
  output logic                     ram_rd_en,
  output logic [address_width-1:0] ram_rd_addr,
  input  logic [data_width-1:0]    ram_rd_data
);

  localparam logic [address_width-1:0] last_addr  = address_width'(RAM_size - 1);
  localparam logic [address_width:0]   full_count = (address_width + 1)'(RAM_size);

  logic [address_width-1:0] wr_ptr;
  logic [address_width-1:0] rd_ptr;
  logic                     pop_acc;
  logic                     push_acc;

  assign full  = (count == full_count);
  assign empty = (count == '0);

  // Requests are gated by rst so the SRAM sees no strobes during a reset cycle.
  assign pop_acc  = ~rst & pop & ~empty;
  assign push_acc = ~rst & push & (~full | pop_acc);

  assign ram_wr_en   = push_acc;
  assign ram_rd_en   = pop_acc;
  assign ram_wr_addr = wr_ptr;
  assign ram_rd_addr = rd_ptr;
  assign ram_wr_data = push_data;
  assign pop_data    = ram_rd_data;

  // Explicit wrap so depths that are not a power of two work.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= (wr_ptr == last_addr) ? '0 : wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= (rd_ptr == last_addr) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= pop_acc;
      if (push & ~push_acc) overflow  <= 1'b1;
      if (pop & empty)      underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - bench for sram_fifo_ctrl at depths 16 and 12 against a queue model
module tb_sram_fifo_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, push, pop;
  logic [7:0] push_data;

  logic [7:0] pop_data [2];
  logic [7:0] ram_wr_data [2];
  logic       pop_valid [2], full [2], empty [2], overflow [2], underflow [2];
  logic       ram_wr_en [2], ram_rd_en [2];
  logic [4:0] count [2];
  logic [3:0] ram_wr_addr [2], ram_rd_addr [2];
  logic [7:0] rd_data0, rd_data1;
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];

  sram_fifo_ctrl #(.data_width(8), .RAM_size(16), .address_width(4)) dut16 (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data[0]), .pop_valid(pop_valid[0]), .full(full[0]), .empty(empty[0]),
    .count(count[0]), .overflow(overflow[0]), .underflow(underflow[0]),
    .ram_wr_en(ram_wr_en[0]), .ram_wr_addr(ram_wr_addr[0]), .ram_wr_data(ram_wr_data[0]),
    .ram_rd_en(ram_rd_en[0]), .ram_rd_addr(ram_rd_addr[0]), .ram_rd_data(rd_data0)
  );

  sram_fifo_ctrl #(.data_width(8), .RAM_size(12), .address_width(4)) dut12 (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data[1]), .pop_valid(pop_valid[1]), .full(full[1]), .empty(empty[1]),
    .count(count[1]), .overflow(overflow[1]), .underflow(underflow[1]),
    .ram_wr_en(ram_wr_en[1]), .ram_wr_addr(ram_wr_addr[1]), .ram_wr_data(ram_wr_data[1]),
    .ram_rd_en(ram_rd_en[1]), .ram_rd_addr(ram_rd_addr[1]), .ram_rd_data(rd_data1)
  );

  // Behavioural dual-port SRAMs: registered read, old data on same-edge read/write.
  always_ff @(posedge clk) begin
    if (rst) rd_data0 <= '0;
    else begin
      if (ram_wr_en[0]) mem0[ram_wr_addr[0]] <= ram_wr_data[0];
      if (ram_rd_en[0]) rd_data0 <= mem0[ram_rd_addr[0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data1 <= '0;
    else begin
      if (ram_wr_en[1]) mem1[ram_wr_addr[1]] <= ram_wr_data[1];
      if (ram_rd_en[1]) rd_data1 <= mem1[ram_rd_addr[1]];
    end
  end

  int         checks = 0;
  int         errors = 0;
  int         depth [2] = '{16, 12};
  logic [7:0] q [2][$];
  int         n_push [2], n_pop [2];
  bit         m_of [2], m_uf [2], m_pv [2];
  logic [7:0] m_pd [2];

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed %0h expected %0h", tag, inst, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      n_push[i] = 0;
      n_pop[i]  = 0;
      m_of[i]   = 1'b0;
      m_uf[i]   = 1'b0;
      m_pv[i]   = 1'b0;
    end
  endtask

  task automatic cycle(input bit r, input bit ps, input bit pp, input logic [7:0] d);
    bit pa [2];
    bit wa [2];
    @(negedge clk);
    rst = r; push = ps; pop = pp; push_data = d;
    #1;
    for (int i = 0; i < 2; i++) begin
      int sz;
      sz    = q[i].size();
      pa[i] = !r && pp && sz > 0;
      wa[i] = !r && ps && (sz < depth[i] || pa[i]);
      chk("count", i, 32'(count[i]), sz);
      chk("full", i, 32'(full[i]), 32'(sz == depth[i]));
      chk("empty", i, 32'(empty[i]), 32'(sz == 0));
      chk("overflow", i, 32'(overflow[i]), 32'(m_of[i]));
      chk("underflow", i, 32'(underflow[i]), 32'(m_uf[i]));
      chk("pop_valid", i, 32'(pop_valid[i]), 32'(m_pv[i]));
      if (m_pv[i]) chk("pop_data", i, 32'(pop_data[i]), 32'(m_pd[i]));
      chk("ram_wr_en", i, 32'(ram_wr_en[i]), 32'(wa[i]));
      chk("ram_rd_en", i, 32'(ram_rd_en[i]), 32'(pa[i]));
      chk("ram_wr_addr", i, 32'(ram_wr_addr[i]), n_push[i] % depth[i]);
      chk("ram_rd_addr", i, 32'(ram_rd_addr[i]), n_pop[i] % depth[i]);
      if (wa[i]) chk("ram_wr_data", i, 32'(ram_wr_data[i]), 32'(d));
    end
    @(posedge clk);
    if (r) model_reset();
    else begin
      for (int i = 0; i < 2; i++) begin
        if (pp && q[i].size() == 0) m_uf[i] = 1'b1;
        if (ps && !wa[i]) m_of[i] = 1'b1;
        m_pv[i] = pa[i];
        if (pa[i]) begin
          m_pd[i] = q[i].pop_front();
          n_pop[i]++;
        end
        if (wa[i]) begin
          q[i].push_back(d);
          n_push[i]++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    repeat (2) @(posedge clk);
    model_reset();

    repeat (2) cycle(0, 0, 0, 8'h00);

    // Fill with 0x11..0x20, then drain in order.
    for (int k = 0; k < 16; k++) cycle(0, 1, 0, 8'(8'h11 + k));
    cycle(0, 0, 0, 8'h00);
    for (int k = 0; k < 16; k++) cycle(0, 0, 1, 8'h00);
    repeat (2) cycle(0, 0, 0, 8'h00);

    // Push and pop together while full.
    cycle(1, 0, 0, 8'h00);
    for (int k = 0; k < 16; k++) cycle(0, 1, 0, 8'(8'h11 + k));
    cycle(0, 1, 1, 8'hAA);
    for (int k = 0; k < 16; k++) cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 0, 8'h00);

    // Rejected push on full, rejected pop on empty.
    cycle(1, 0, 0, 8'h00);
    for (int k = 0; k < 16; k++) cycle(0, 1, 0, 8'(8'h40 + k));
    cycle(0, 1, 0, 8'hBB);
    repeat (2) cycle(0, 0, 0, 8'h00);
    cycle(1, 0, 0, 8'h00);
    cycle(0, 0, 1, 8'h00);
    cycle(0, 1, 1, 8'h77);
    repeat (2) cycle(0, 0, 0, 8'h00);

    // Streaming one push and one pop per cycle across the wrap point.
    cycle(1, 0, 0, 8'h00);
    cycle(0, 1, 0, 8'h80);
    for (int k = 1; k <= 30; k++) cycle(0, 1, 1, 8'(8'h80 + k));
    cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 0, 8'h00);

    // Reset mid-stream with five entries held.
    cycle(1, 0, 0, 8'h00);
    for (int k = 0; k < 5; k++) cycle(0, 1, 0, 8'(8'h30 + k));
    cycle(1, 1, 1, 8'h33);
    cycle(0, 1, 0, 8'h5A);
    cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 0, 8'h00);

    // Random traffic with push-heavy then pop-heavy phases and rare resets.
    for (int k = 0; k < 800; k++) begin
      bit r, ps, pp;
      r  = ($urandom_range(0, 99) == 0);
      ps = ($urandom_range(0, 99) < ((k / 100) % 2 == 0 ? 75 : 35));
      pp = ($urandom_range(0, 99) < ((k / 100) % 2 == 0 ? 35 : 75));
      cycle(r, ps, pp, 8'($urandom));
    end
    cycle(0, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
